// File: rtl/exe_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : exe_stage_pkg                                                |
// | Description : Shared types and constants for the execute stage: bus       |
// |               widths, decode->execute bus layout, div_op bit positions,    |
// |               divider state encodings, ALU op bit positions and the        |
// |               combinational ALU function.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package exe_stage_pkg;

  localparam int DS_TO_ES_BUS_WD = 280;
  localparam int ES_TO_MS_BUS_WD = 135;

  // div_op is one-hot {div, divu, rem, remu}; all-zero means "not a divide"
  localparam int DIV_OP_DIV  = 3;
  localparam int DIV_OP_DIVU = 2;
  localparam int DIV_OP_REM  = 1;
  localparam int DIV_OP_REMU = 0;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // alu_op is one-hot
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  // Field order matches the decode->execute bus, MSB first
  typedef struct packed {
    logic [11:0] alu_op;
    logic [3:0]  div_op;
    logic        res_from_mem;
    logic        mem_we;
    logic        gr_we;
    logic [4:0]  dest;
    logic [63:0] src1;
    logic [63:0] src2;
    logic [63:0] st_data;
    logic [63:0] pc;
  } ds_to_es_t;

  // Purely combinational 64-bit ALU; carries and overflow are discarded
  function automatic logic [63:0] alu(input logic [11:0] op,
                                      input logic [63:0] a,
                                      input logic [63:0] b);
    logic [63:0] r;
    r = '0;
    if      (op[ALU_ADD])  r = a + b;
    else if (op[ALU_SUB])  r = a - b;
    else if (op[ALU_SLT])  r = {63'd0, $signed(a) < $signed(b)};
    else if (op[ALU_SLTU]) r = {63'd0, a < b};
    else if (op[ALU_AND])  r = a & b;
    else if (op[ALU_NOR])  r = ~(a | b);
    else if (op[ALU_OR])   r = a | b;
    else if (op[ALU_XOR])  r = a ^ b;
    else if (op[ALU_SLL])  r = a << b[5:0];
    else if (op[ALU_SRL])  r = a >> b[5:0];
    else if (op[ALU_SRA])  r = $signed(a) >>> b[5:0];
    else if (op[ALU_LUI])  r = b;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exe_stage_div_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : div_iter                                                     |
// | Description : Iterative restoring radix-2 64-bit divider, one quotient     |
// |               bit per cycle (64 BUSY cycles). Handles signed/unsigned      |
// |               div/rem, divide-by-zero and the -2^63 / -1 overflow case.    |
// | Ports       : clk, reset (async, active-high)                              |
// |               start  - begin a divide (honoured only in IDLE)              |
// |               op     - one-hot {div, divu, rem, remu}                      |
// |               a, b   - dividend, divisor (held stable until ack)           |
// |               ack    - result consumed, return to IDLE                     |
// |               done   - result valid (DONE state)                           |
// |               result - quotient or remainder selected by op                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module div_iter
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        ack,
  output logic        done,
  output logic [63:0] result
);

  localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;

  div_state_e  state_q;
  logic [6:0]  cnt_q;
  logic [63:0] quo_q;      // dividend bits shift out the top, quotient bits in
  logic [63:0] rem_q;
  logic [63:0] dvs_q;
  logic        neg_quo_q;
  logic        neg_rem_q;
  logic        by_zero_q;
  logic        ovf_q;

  logic        w_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [63:0] w_a_mag;
  logic [63:0] w_b_mag;
  logic [64:0] w_trial;
  logic [64:0] w_diff;
  logic        w_fits;
  logic [63:0] w_quo;
  logic [63:0] w_rem;

  always_comb begin
    w_signed = op[DIV_OP_DIV] | op[DIV_OP_REM];
    w_a_neg  = w_signed & a[63];
    w_b_neg  = w_signed & b[63];
    w_a_mag  = w_a_neg ? (64'd0 - a) : a;
    w_b_mag  = w_b_neg ? (64'd0 - b) : b;

    // 65-bit trial so the shifted partial remainder never overflows;
    // bit 64 of the difference is the borrow
    w_trial  = {rem_q, quo_q[63]};
    w_diff   = w_trial - {1'b0, dvs_q};
    w_fits   = ~w_diff[64];

    w_quo    = neg_quo_q ? (64'd0 - quo_q) : quo_q;
    w_rem    = neg_rem_q ? (64'd0 - rem_q) : rem_q;
    // a is the instruction's own operand, still held in the ES register
    if (by_zero_q) begin
      w_quo = '1;
      w_rem = a;
    end else if (ovf_q) begin
      w_quo = a;
      w_rem = '0;
    end

    result = (op[DIV_OP_DIV] | op[DIV_OP_DIVU]) ? w_quo : w_rem;
  end

  assign done = (state_q == DIV_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      by_zero_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start) begin
            state_q   <= DIV_BUSY;
            cnt_q     <= '0;
            quo_q     <= w_a_mag;
            dvs_q     <= w_b_mag;
            rem_q     <= '0;
            neg_quo_q <= w_a_neg ^ w_b_neg;
            neg_rem_q <= w_a_neg;
            by_zero_q <= (b == 64'd0);
            ovf_q     <= w_signed && (a == INT_MIN) && (b == '1);
          end
        end
        DIV_BUSY: begin
          // When the trial does not fit it is below the divisor, so 64 bits hold it
          rem_q <= w_fits ? w_diff[63:0] : w_trial[63:0];
          quo_q <= {quo_q[62:0], w_fits};
          cnt_q <= cnt_q + 7'd1;
          if (cnt_q == 7'd63) begin
            state_q <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (ack) begin
            state_q <= DIV_IDLE;
          end
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/exe_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : exe_stage                                                    |
// | Description : Execute stage of the 5-stage 64-bit pipeline. Registers one  |
// |               instruction from decode, computes its result with the ALU    |
// |               or the iterative divider, issues loads/stores to the data    |
// |               SRAM on handoff and drives the execute->memory bus.          |
// | Ports       : clk, reset (async, active-high)                              |
// |               ms_allowin / es_allowin       - pipeline back-pressure       |
// |               ds_to_es_valid / ds_to_es_bus - instruction from decode      |
// |               es_to_ms_valid / es_to_ms_bus - instruction to mem_stage     |
// |               data_sram_*                   - data SRAM request            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       data_sram_en,
  output logic [7:0]                 data_sram_wen,
  output logic [63:0]                data_sram_addr,
  output logic [63:0]                data_sram_wdata
);

  logic      es_valid_q;
  logic      es_valid_d;
  ds_to_es_t ds_bus_q;
  ds_to_es_t ds_bus_d;

  logic        w_is_div;
  logic        w_ready_go;
  logic        w_handoff;
  logic        w_div_done;
  logic [63:0] w_div_res;
  logic [63:0] w_alu_res;
  logic [63:0] w_result;

  assign w_is_div   = |ds_bus_q.div_op;
  assign w_ready_go = !w_is_div || w_div_done;

  assign es_allowin     = !es_valid_q || (w_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid_q && w_ready_go;
  assign w_handoff      = es_to_ms_valid && ms_allowin;

  always_comb begin
    es_valid_d = es_valid_q;
    ds_bus_d   = ds_bus_q;
    if (es_allowin) begin
      es_valid_d = ds_to_es_valid;
    end
    if (ds_to_es_valid && es_allowin) begin
      ds_bus_d = ds_to_es_bus;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      es_valid_q <= 1'b0;
      ds_bus_q   <= '0;
    end else begin
      es_valid_q <= es_valid_d;
      ds_bus_q   <= ds_bus_d;
    end
  end

  assign w_alu_res = alu(ds_bus_q.alu_op, ds_bus_q.src1, ds_bus_q.src2);

  div_iter u_div_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (es_valid_q && w_is_div),
    .op     (ds_bus_q.div_op),
    .a      (ds_bus_q.src1),
    .b      (ds_bus_q.src2),
    .ack    (w_handoff),
    .done   (w_div_done),
    .result (w_div_res)
  );

  assign w_result = w_is_div ? w_div_res : w_alu_res;

  assign es_to_ms_bus = {ds_bus_q.res_from_mem, ds_bus_q.gr_we, ds_bus_q.dest,
                         w_result, ds_bus_q.pc};

  // Access only when mem_stage takes the instruction this cycle, so the
  // synchronous read data lines up with the load arriving in MEM
  assign data_sram_en    = es_valid_q && (ds_bus_q.res_from_mem || ds_bus_q.mem_we)
                           && ms_allowin;
  assign data_sram_wen   = {8{data_sram_en && ds_bus_q.mem_we}};
  assign data_sram_addr  = w_alu_res;
  assign data_sram_wdata = ds_bus_q.st_data;

endmodule
`default_nettype wire

// File: tb/tb_exe_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_exe_stage                                                 |
// | Description : Scoreboard bench for exe_stage. Stimulus pushes expected     |
// |               execute->memory bus values and SRAM requests (with the       |
// |               cycle they must appear in); monitors pop and compare.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_exe_stage;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         ms_allowin = 1'b1;
  logic         es_allowin;
  logic         ds_to_es_valid = 1'b0;
  logic [279:0] ds_to_es_bus = '0;
  logic         es_to_ms_valid;
  logic [134:0] es_to_ms_bus;
  logic         data_sram_en;
  logic [7:0]   data_sram_wen;
  logic [63:0]  data_sram_addr;
  logic [63:0]  data_sram_wdata;

  exe_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ms_allowin      (ms_allowin),
    .es_allowin      (es_allowin),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_to_es_bus    (ds_to_es_bus),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [11:0] OP_ADD = 12'h001;
  localparam logic [11:0] OP_SUB = 12'h002;
  localparam logic [11:0] OP_XOR = 12'h080;
  localparam logic [11:0] OP_SRA = 12'h400;
  localparam logic [3:0]  D_DIV  = 4'b1000;
  localparam logic [3:0]  D_DIVU = 4'b0100;
  localparam logic [3:0]  D_REM  = 4'b0010;
  localparam logic [3:0]  D_REMU = 4'b0001;
  localparam logic [63:0] MIN64  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [134:0] bus;
    int           cyc;
  } exp_t;

  typedef struct {
    logic [7:0]  wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          cyc;
  } sram_t;

  exp_t  sb_q[$];
  sram_t sr_q[$];
  exp_t  mon_e;
  sram_t mon_s;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [134:0] act, input logic [134:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [279:0] mk(input logic [11:0] aop, input logic [3:0] dop,
                                      input logic rfm, input logic mwe, input logic gwe,
                                      input logic [4:0] dst, input logic [63:0] s1,
                                      input logic [63:0] s2, input logic [63:0] st,
                                      input logic [63:0] pc);
    return {aop, dop, rfm, mwe, gwe, dst, s1, s2, st, pc};
  endfunction

  // Offer one instruction, wait for acceptance, push its expectations.
  // lat: cycles from entry to offer; stall: cycles ms_allowin is held low.
  task automatic send(input logic [279:0] bus, input logic [63:0] res,
                      input int lat, input int stall);
    int    waited;
    int    t;
    exp_t  e;
    sram_t s;
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = bus;
    waited = 0;
    @(negedge clk);
    while (!es_allowin && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!es_allowin) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: es_allowin got 0 expected 1 (cycle %0d)", cyc);
    end
    @(posedge clk);
    #1;
    ds_to_es_valid = 1'b0;
    t = cyc;
    e.bus = {bus[263], bus[261], bus[260:256], res, bus[63:0]};
    e.cyc = t + lat + stall;
    sb_q.push_back(e);
    if (bus[263] || bus[262]) begin
      s.wen   = {8{bus[262]}};
      s.addr  = res;
      s.wdata = bus[127:64];
      s.cyc   = t + lat + stall;
      sr_q.push_back(s);
    end
    if (stall > 0) begin
      ms_allowin = 1'b0;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk("stall_allowin", 135'(es_allowin), 135'(0));
        chk("stall_sram_en", 135'(data_sram_en), 135'(0));
        @(posedge clk);
        #1;
      end
      ms_allowin = 1'b1;
    end
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    while ((sb_q.size() != 0 || sr_q.size() != 0) && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (sb_q.size() != 0 || sr_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: pending got %0d expected 0",
               sb_q.size() + sr_q.size());
      sb_q.delete();
      sr_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [279:0] alu_ins(input logic [11:0] aop, input logic [63:0] s1,
                                           input logic [63:0] s2, input logic [63:0] pc);
    return mk(aop, 4'b0, 1'b0, 1'b0, 1'b1, 5'd3, s1, s2, 64'd0, pc);
  endfunction

  function automatic logic [279:0] div_ins(input logic [3:0] dop, input logic [63:0] s1,
                                           input logic [63:0] s2, input logic [63:0] pc);
    return mk(12'd0, dop, 1'b0, 1'b0, 1'b1, 5'd9, s1, s2, 64'd0, pc);
  endfunction

  // Output monitor: compare whenever an instruction is handed to MEM
  always @(negedge clk) begin
    if (es_to_ms_valid && ms_allowin) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_handoff: got bus %0h expected none (cycle %0d)",
                 es_to_ms_bus, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("out_bus", es_to_ms_bus, mon_e.bus);
        chk("out_cycle", 135'(cyc), 135'(mon_e.cyc));
      end
    end
    if (data_sram_en) begin
      if (sr_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_sram: got en 1 addr %0h expected en 0 (cycle %0d)",
                 data_sram_addr, cyc);
      end else begin
        mon_s = sr_q.pop_front();
        chk("sram_wen", 135'(data_sram_wen), 135'(mon_s.wen));
        chk("sram_addr", 135'(data_sram_addr), 135'(mon_s.addr));
        chk("sram_wdata", 135'(data_sram_wdata), 135'(mon_s.wdata));
        chk("sram_cycle", 135'(cyc), 135'(mon_s.cyc));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Asynchronous reset: outputs must clear before any clock edge
    #1 reset = 1'b1;
    #1;
    chk("rst_es_to_ms_valid", 135'(es_to_ms_valid), 135'(0));
    chk("rst_es_allowin", 135'(es_allowin), 135'(1));
    chk("rst_sram_en", 135'(data_sram_en), 135'(0));
    chk("rst_sram_wen", 135'(data_sram_wen), 135'(0));
    chk("rst_bus", es_to_ms_bus, 135'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // ADD 5+7, offered in the cycle it enters ES
    send(alu_ins(OP_ADD, 64'd5, 64'd7, 64'h100), 64'd12, 0, 0);
    wait_idle();

    // Back-to-back ALU ops, one per cycle
    send(alu_ins(OP_SUB, 64'd5, 64'd7, 64'h104), 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
    send(alu_ins(OP_XOR, 64'hF0F0, 64'h0FF0, 64'h108), 64'hFF00, 0, 0);
    send(alu_ins(OP_SRA, 64'hFFFF_FFFF_FFFF_FFF0, 64'd2, 64'h10C),
         64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
    wait_idle();

    // Load to 0x1000 stalled 3 cycles by mem_stage
    send(mk(OP_ADD, 4'b0, 1'b1, 1'b0, 1'b1, 5'd4, 64'h0FF0, 64'h10, 64'd0, 64'h110),
         64'h1000, 0, 3);
    wait_idle();

    // Store 0xDEADBEEF to 0x2008
    send(mk(OP_ADD, 4'b0, 1'b0, 1'b1, 1'b0, 5'd0, 64'h2000, 64'h8, 64'hDEAD_BEEF, 64'h114),
         64'h2008, 0, 0);
    wait_idle();

    // DIV -100/7, with a check that the stage blocks while BUSY
    send(div_ins(D_DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'h200),
         64'hFFFF_FFFF_FFFF_FFF2, 65, 0);
    @(negedge clk);
    chk("busy_allowin", 135'(es_allowin), 135'(0));
    chk("busy_es_to_ms_valid", 135'(es_to_ms_valid), 135'(0));
    wait_idle();
    send(div_ins(D_REM, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'h204),
         64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
    wait_idle();
    send(div_ins(D_DIV, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'h208),
         64'hFFFF_FFFF_FFFF_FFF2, 65, 0);
    // REM of 100 / -7 follows immediately: enters on the handoff cycle
    send(div_ins(D_REM, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'h20C), 64'd2, 65, 0);
    wait_idle();

    // Special cases
    send(div_ins(D_DIVU, 64'd5, 64'd0, 64'h210), ONES, 65, 0);
    wait_idle();
    send(div_ins(D_REMU, 64'd5, 64'd0, 64'h214), 64'd5, 65, 0);
    wait_idle();
    send(div_ins(D_DIV, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'h218), ONES, 65, 0);
    wait_idle();
    send(div_ins(D_REM, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'h21C),
         64'hFFFF_FFFF_FFFF_FFFB, 65, 0);
    wait_idle();
    send(div_ins(D_DIV, MIN64, ONES, 64'h220), MIN64, 65, 0);
    wait_idle();
    send(div_ins(D_REM, MIN64, ONES, 64'h224), 64'd0, 65, 0);
    wait_idle();

    // Unsigned full-width divide, then an ADD that enters on the handoff cycle
    send(div_ins(D_DIVU, ONES, 64'd2, 64'h228), 64'h7FFF_FFFF_FFFF_FFFF, 65, 0);
    send(alu_ins(OP_ADD, 64'd40, 64'd2, 64'h22C), 64'd42, 0, 0);
    wait_idle();
    send(div_ins(D_REMU, 64'd100, 64'd7, 64'h230), 64'd2, 65, 0);
    wait_idle();

    // Divide result held while mem_stage stalls past DONE
    send(div_ins(D_DIV, 64'd1000, 64'd10, 64'h234), 64'd100, 0, 67);
    wait_idle();

    // Reset 30 cycles into a divide discards it
    send(div_ins(D_DIV, 64'd77, 64'd7, 64'h300), 64'd11, 65, 0);
    repeat (30) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_es_to_ms_valid", 135'(es_to_ms_valid), 135'(0));
    chk("midrst_es_allowin", 135'(es_allowin), 135'(1));
    chk("midrst_sram_en", 135'(data_sram_en), 135'(0));
    sb_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    send(alu_ins(OP_ADD, 64'd1, 64'd2, 64'h304), 64'd3, 0, 0);
    wait_idle();
    send(div_ins(D_DIVU, 64'd100, 64'd7, 64'h308), 64'd14, 65, 0);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
